muldiv_sequencer: RTL and testbench

- Next-generation control block alongside the ID-stage decoder. Sequences multi-cycle MULT/MULTU/DIV/DIVU operations and owns the HI/LO write.
- Generates the ID-stage stall needed when HI/LO access or a second multiply/divide arrives while the unit is still busy.
- Latencies are parametrised per operation class.
- Sits in ID, beside the single-cycle control decoder and hazard unit. Its stall output is ORed into the pipeline stall by the top level.

---
 rtl/muldiv_sequencer_if.sv | 21 ++
 rtl/muldiv_sequencer.sv | 57 +++++
 tb/tb_muldiv_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: ID-stage decode inputs and multiply/divide sequencing outputs.
interface muldiv_sequencer_if;
    logic       id_stall;
    logic [5:0] id_opcode;
    logic [5:0] id_funct;
    logic       id_md_start;
    logic [1:0] id_md_op;
    logic       id_md_stall;
    logic       md_busy;
    logic       md_done;

    modport master (
        output id_stall, id_opcode, id_funct,
        input  id_md_start, id_md_op, id_md_stall, md_busy, md_done
    );

    modport slave (
        input  id_stall, id_opcode, id_funct,
        output id_md_start, id_md_op, id_md_stall, md_busy, md_done
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: sequences multi-cycle MULT/MULTU/DIV/DIVU, drives the HI/LO write
// strobe and stalls ID while HI/LO or a further mul/div would collide with a busy unit.
module muldiv_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input logic              clock,
    input logic              reset,
    muldiv_sequencer_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0]       op, op_nx;
    logic             is_md, is_hilo, start, busy;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            op    <= 2'b00;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op    <= op_nx;
        end
    end

    always_comb begin
        is_md    = bus.id_opcode == 6'b000000 && bus.id_funct[5:2] == 4'b0110;
        is_hilo  = bus.id_opcode == 6'b000000 && bus.id_funct[5:2] == 4'b0100;
        busy     = state == BUSY;
        start    = !busy && is_md && !bus.id_stall;
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op;
        if (start) begin
            state_nx = BUSY;
            op_nx    = bus.id_funct[1:0];
            cnt_nx   = bus.id_funct[1] ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
        end else if (busy) begin
            // cnt holds at zero on the final cycle so it never wraps
            state_nx = cnt == '0 ? IDLE : BUSY;
            cnt_nx   = cnt == '0 ? cnt : cnt - CNT_W'(1);
        end
    end

    always_comb begin
        bus.id_md_start = start;
        bus.id_md_op    = op;
        bus.md_busy     = busy;
        bus.md_done     = busy && cnt == '0;
        bus.id_md_stall = busy && (is_md || is_hilo);
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random instruction streams scored against a
// cycle-count reference model; per-cycle outputs and md_done events are queued and checked.
module tb_muldiv_sequencer;
    localparam int MUL_N = 4;
    localparam int DIV_N = 8;

    typedef struct {
        logic       start;
        logic [1:0] op;
        logic       stall;
        logic       busy;
        logic       done;
    } exp_t;

    typedef struct {
        int         cyc;
        logic [1:0] op;
    } done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   busy_left = 0;
    logic [1:0] cur_op = 2'b00;
    exp_t  exp_q[$];
    done_t done_q[$];

    muldiv_sequencer_if bus ();

    muldiv_sequencer #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .CNT_W(6)) dut (
        .clock(clk),
        .reset(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_start"}, int'(bus.id_md_start), 0);
        chk({tag, "_op"},    int'(bus.id_md_op), 0);
        chk({tag, "_stall"}, int'(bus.id_md_stall), 0);
        chk({tag, "_busy"},  int'(bus.md_busy), 0);
        chk({tag, "_done"},  int'(bus.md_done), 0);
    endtask

    // Model: the unit is busy for N cycles after a start; the last of those is md_done.
    task automatic step(input logic [5:0] opc, input logic [5:0] fn, input logic stl);
        exp_t e;
        logic md, hilo, b;
        int   n;
        @(posedge clk);
        #1;
        bus.id_opcode = opc;
        bus.id_funct  = fn;
        bus.id_stall  = stl;
        md   = opc == 0 && fn inside {6'd24, 6'd25, 6'd26, 6'd27};
        hilo = opc == 0 && fn inside {6'd16, 6'd17, 6'd18, 6'd19};
        b    = busy_left > 0;
        n    = fn[1] ? DIV_N : MUL_N;
        e.start = md && !stl && !b;
        e.op    = cur_op;
        e.stall = b && (md || hilo);
        e.busy  = b;
        e.done  = busy_left == 1;
        exp_q.push_back(e);
        if (b) busy_left--;
        if (e.start) begin
            done_q.push_back('{cyc + n, fn[1:0]});
            busy_left = n;
            cur_op    = fn[1:0];
        end
    endtask

    task automatic nops(input int k);
        for (int i = 0; i < k; i++) step(6'd0, 6'd0, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("start", int'(bus.id_md_start), int'(e.start));
            chk("op",    int'(bus.id_md_op),    int'(e.op));
            chk("stall", int'(bus.id_md_stall), int'(e.stall));
            chk("busy",  int'(bus.md_busy),     int'(e.busy));
            chk("done",  int'(bus.md_done),     int'(e.done));
        end
    end

    always @(negedge clk) begin
        done_t d;
        if (rst_n && bus.md_done) begin
            if (done_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                d = done_q.pop_front();
                chk("done_cycle", cyc, d.cyc);
                chk("done_op", int'(bus.id_md_op), int'(d.op));
            end
        end
    end

    initial begin
        bus.id_opcode = 6'd0;
        bus.id_funct  = 6'd0;
        bus.id_stall  = 1'b0;
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        step(6'd0, 6'd24, 1'b0);
        nops(6);

        step(6'd0, 6'd27, 1'b0);
        for (int i = 0; i < 9; i++) step(6'd0, 6'd18, 1'b0);
        nops(2);

        step(6'd0, 6'd24, 1'b1);
        step(6'd0, 6'd24, 1'b1);
        step(6'd0, 6'd24, 1'b0);
        nops(6);

        step(6'd0, 6'd26, 1'b0);
        for (int i = 0; i < 9; i++) step(6'd0, 6'd24, 1'b0);
        nops(6);

        step(6'd0, 6'd26, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(6'd0, 6'd33, 1'b0);
            step(6'd35, 6'd5, 1'b0);
        end
        nops(2);

        // Asynchronous reset three cycles into a divide abandons it without md_done.
        step(6'd0, 6'd26, 1'b0);
        nops(3);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        busy_left = 0;
        cur_op    = 2'b00;
        done_q.delete();
        @(posedge clk);
        #1;
        chk_zero("held_reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        nops(12);

        for (int i = 0; i < 2000; i++) begin
            int k;
            logic [5:0] opc, fn;
            k   = $urandom_range(0, 9);
            opc = 6'd0;
            fn  = 6'($urandom_range(0, 63));
            if (k < 4) fn = {4'b0110, 2'($urandom_range(0, 3))};
            else if (k < 6) fn = {4'b0100, 2'($urandom_range(0, 3))};
            else if (k == 6) fn = 6'd33;
            else if (k == 7) opc = 6'd35;
            step(opc, fn, $urandom_range(0, 3) == 0);
        end

        for (int i = 0; i < 100 && busy_left > 0; i++) nops(1);
        nops(1);
        @(negedge clk);
        #1;
        chk("done_pending", done_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
